// File: rtl/adc_filter_pkg.sv
// Shared types and defaults for the ADC moving-average filter.
// The running-sum width is derived here so the top and any user agree on it.
package adc_filter_pkg;

  typedef enum logic {INIT, RUN} avg_state_t;

  localparam int ADC_WIDTH      = 12;
  localparam int AVG_LOG2_DEPTH = 8;

  // A sum of 2^log2_d samples of data_w bits needs log2_d extra bits of headroom.
  function automatic int sum_width(input int data_w, input int log2_d);
    return data_w + log2_d;
  endfunction

endpackage

// File: rtl/sample_ring_buffer.sv
// Register-array sample store with one write port and a combinational read port.
// Storage has no reset; the owner zero-fills it.
module sample_ring_buffer #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/adc_moving_average.sv
// Boxcar moving average over 2^LOG2_DEPTH ADC samples using a circular buffer
// and a running sum; the buffer is zero-filled after reset or clear.
module adc_moving_average
  import adc_filter_pkg::*;
#(
  parameter int DATA_WIDTH = ADC_WIDTH,
  parameter int LOG2_DEPTH = AVG_LOG2_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_in,
  output logic                  sample_ready,
  output logic [DATA_WIDTH-1:0] avg_out,
  output logic                  avg_valid,
  output logic                  filled
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SUM_W = sum_width(DATA_WIDTH, LOG2_DEPTH);
  localparam logic [LOG2_DEPTH-1:0] LAST_SLOT = LOG2_DEPTH'(DEPTH - 1);
  localparam logic [LOG2_DEPTH-1:0] PTR_ONE   = LOG2_DEPTH'(1);
  localparam logic [LOG2_DEPTH:0]   FULL_CNT  = (LOG2_DEPTH + 1)'(DEPTH);
  localparam logic [LOG2_DEPTH:0]   LAST_CNT  = (LOG2_DEPTH + 1)'(DEPTH - 1);
  localparam logic [LOG2_DEPTH:0]   CNT_ONE   = (LOG2_DEPTH + 1)'(1);

  avg_state_t state, next_state;

  logic [LOG2_DEPTH-1:0] init_cnt;
  logic [LOG2_DEPTH-1:0] wr_ptr;
  logic [LOG2_DEPTH-1:0] buf_waddr;
  logic [DATA_WIDTH-1:0] buf_wdata;
  logic [DATA_WIDTH-1:0] oldest;
  logic [SUM_W-1:0]      sum;
  logic [SUM_W-1:0]      next_sum;
  logic [LOG2_DEPTH:0]   fill_cnt;
  logic                  buf_we;
  logic                  accept;

  sample_ring_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(LOG2_DEPTH)
  ) u_ring (
    .clk  (clk),
    .we   (buf_we),
    .waddr(buf_waddr),
    .wdata(buf_wdata),
    .raddr(wr_ptr),
    .rdata(oldest)
  );

  // The slot about to be overwritten holds the oldest sample, so one add and
  // one subtract keep the sum equal to the buffer total.
  assign next_sum = sum + SUM_W'(sample_in) - SUM_W'(oldest);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= INIT;
    else          state <= next_state;
  end

  // clear overrides everything: no write, no accept, back to zero-fill.
  always_comb begin
    next_state   = state;
    sample_ready = 1'b0;
    accept       = 1'b0;
    buf_we       = 1'b0;
    buf_waddr    = wr_ptr;
    buf_wdata    = sample_in;
    case (state)
      INIT: begin
        buf_we    = 1'b1;
        buf_waddr = init_cnt;
        buf_wdata = '0;
        if (init_cnt == LAST_SLOT) next_state = RUN;
      end
      RUN: begin
        sample_ready = 1'b1;
        accept       = sample_valid;
        buf_we       = sample_valid;
      end
      default: next_state = INIT;
    endcase
    if (clear) begin
      next_state = INIT;
      accept     = 1'b0;
      buf_we     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_cnt  <= '0;
      wr_ptr    <= '0;
      sum       <= '0;
      avg_out   <= '0;
      avg_valid <= 1'b0;
      fill_cnt  <= '0;
      filled    <= 1'b0;
    end else if (clear) begin
      init_cnt  <= '0;
      wr_ptr    <= '0;
      sum       <= '0;
      avg_out   <= '0;
      avg_valid <= 1'b0;
      fill_cnt  <= '0;
      filled    <= 1'b0;
    end else begin
      avg_valid <= accept;
      if (state == INIT) init_cnt <= init_cnt + PTR_ONE;
      if (accept) begin
        sum     <= next_sum;
        wr_ptr  <= wr_ptr + PTR_ONE;
        avg_out <= DATA_WIDTH'(next_sum >> LOG2_DEPTH);
        if (fill_cnt != FULL_CNT) fill_cnt <= fill_cnt + CNT_ONE;
        if (fill_cnt == LAST_CNT) filled <= 1'b1;
      end
    end
  end

endmodule
